// File: rtl/draw_text_grid.sv
// draw_text_grid: overlays a COLS x ROWS grid of 8x16 glyphs on a video stream.
// The character buffer is written by the host or swept to spaces by a clear
// engine. A 3-stage pixel pipeline looks up the cell code, drives the external
// font ROM address, and picks the glyph bit for the compositor.
module draw_text_grid #(
  parameter logic [10:0] X_POS    = 11'd64,
  parameter logic [10:0] Y_POS    = 11'd64,
  parameter int          COLS     = 16,
  parameter int          ROWS     = 4,
  parameter logic [11:0] FG_COLOR = 12'h0_0_0,
  parameter logic [11:0] BG_COLOR = 12'hf_f_f
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        char_we,
  input  logic [10:0] char_addr,
  input  logic [6:0]  char_data,
  input  logic        clear,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        busy,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam int          CELLS     = COLS * ROWS;
  localparam int          AW        = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int          DEPTH     = 1 << AW;
  localparam logic [11:0] X_END     = 12'(X_POS) + 12'(8 * COLS);
  localparam logic [11:0] Y_END     = 12'(Y_POS) + 12'(16 * ROWS);
  localparam logic [10:0] LAST_CELL = 11'(CELLS - 1);
  localparam logic [10:0] NUM_CELLS = 11'(CELLS);
  localparam logic [6:0]  SPACE     = 7'h20;
  localparam int          TW        = 38;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t      state, state_nxt;
  logic [10:0] clr_addr, clr_addr_nxt;
  logic        start_pend, start_pend_nxt;
  logic        host_wr;

  logic [6:0]  char_mem [0:DEPTH-1];

  logic [10:0]   h_off, v_off;
  logic          in_box;
  logic [AW-1:0] cell_idx;
  logic [TW-1:0] tim_in;

  logic [TW-1:0] tim_p1, tim_p2, tim_p3;
  logic          in_box_p1, in_box_p2;
  logic [6:0]    code_p1;
  logic [3:0]    line_p1;
  logic [2:0]    px_p1, px_p2;
  logic          glyph_bit;

  // Inside the box the glyph decides the colour; blanking or outside passes upstream video.
  function automatic logic [11:0] pick_rgb(input logic pass, input logic glyph,
                                           input logic [11:0] under);
    if (pass) return under;
    return glyph ? FG_COLOR : BG_COLOR;
  endfunction

  assign busy = (state == ST_CLEAR);

  // A host write lands only when the clear engine is idle and not about to start.
  assign host_wr = !busy && char_we && !clear && !start_pend && (char_addr < NUM_CELLS);

  // Clear engine state register; reset arms an automatic clear for the release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      clr_addr   <= 11'd0;
      start_pend <= 1'b1;
    end else begin
      state      <= state_nxt;
      clr_addr   <= clr_addr_nxt;
      start_pend <= start_pend_nxt;
    end
  end

  // Clear engine next state: sweep cells 0..CELLS-1, ignore clear while sweeping.
  always_comb begin
    state_nxt      = state;
    clr_addr_nxt   = clr_addr;
    start_pend_nxt = start_pend;
    case (state)
      ST_IDLE: begin
        if (clear || start_pend) begin
          state_nxt      = ST_CLEAR;
          clr_addr_nxt   = 11'd0;
          start_pend_nxt = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (clr_addr == LAST_CELL) state_nxt = ST_IDLE;
        else                       clr_addr_nxt = clr_addr + 11'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Character buffer write port: the sweep owns the port while busy.
  always_ff @(posedge clk) begin
    if (busy)         char_mem[clr_addr[AW-1:0]]  <= SPACE;
    else if (host_wr) char_mem[char_addr[AW-1:0]] <= char_data;
  end

  // Box test is done before using offsets so pixels left/above never wrap into a cell.
  assign h_off    = hcount_in - X_POS;
  assign v_off    = vcount_in - Y_POS;
  assign in_box   = (hcount_in >= X_POS) && ({1'b0, hcount_in} < X_END) &&
                    (vcount_in >= Y_POS) && ({1'b0, vcount_in} < Y_END);
  assign cell_idx = in_box ? AW'({4'd0, v_off[10:4]} * 11'(COLS) + {3'd0, h_off[10:3]})
                           : '0;
  assign tim_in   = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
  assign glyph_bit = font_data[3'd7 - px_p2];

  // Pixel pipeline: cell lookup, font address, glyph select / composite.
  always_ff @(posedge clk) begin
    if (rst) begin
      tim_p1    <= '0;
      in_box_p1 <= 1'b0;
      code_p1   <= 7'd0;
      line_p1   <= 4'd0;
      px_p1     <= 3'd0;
      tim_p2    <= '0;
      in_box_p2 <= 1'b0;
      px_p2     <= 3'd0;
      font_addr <= 11'd0;
      tim_p3    <= '0;
      rgb_out   <= 12'd0;
    end else begin
      // stage 1: box test, cell lookup in the character buffer
      tim_p1    <= tim_in;
      in_box_p1 <= in_box;
      code_p1   <= char_mem[cell_idx];
      line_p1   <= v_off[3:0];
      px_p1     <= h_off[2:0];
      // stage 2: present glyph line address to the font ROM
      tim_p2    <= tim_p1;
      in_box_p2 <= in_box_p1;
      px_p2     <= px_p1;
      font_addr <= {code_p1, line_p1};
      // stage 3: pick the glyph bit and composite
      tim_p3    <= tim_p2;
      rgb_out   <= pick_rgb(tim_p2[13] || tim_p2[12] || !in_box_p2, glyph_bit, tim_p2[11:0]);
    end
  end

  assign hcount_out = tim_p3[37:27];
  assign vcount_out = tim_p3[26:16];
  assign hsync_out  = tim_p3[15];
  assign vsync_out  = tim_p3[14];
  assign hblnk_out  = tim_p3[13];
  assign vblnk_out  = tim_p3[12];

endmodule

// File: doc/draw_text_grid.md
DRAW_TEXT_GRID -- requirements
Module: draw_text_grid

Interface
REQ-001 Parameter X_POS, default 11'd64, left pixel column of the text box.
REQ-002 Parameter Y_POS, default 11'd64, top pixel line of the text box.
REQ-003 Parameter COLS, default 16, characters per row (1..64).
REQ-004 Parameter ROWS, default 4, character rows (1..32).
REQ-005 Parameter FG_COLOR, default 12'h0_0_0, glyph pixel colour.
REQ-006 Parameter BG_COLOR, default 12'hf_f_f, box background colour.
REQ-007 Clock and reset SHALL be a single clock named clk and a synchronous, active-high reset named rst.
REQ-008 Remaining ports SHALL be:
- hcount_in  in  11  pixel column
- vcount_in  in  11  pixel line
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing
- rgb_in  in  12  upstream pixel
- char_we  in  1  char write strobe
- char_addr  in  11  linear cell index, row*COLS+col
- char_data  in  7  char code
- clear  in  1  clear-buffer pulse
- font_addr  out  11  {code[6:0], glyph line[3:0]}
- font_data  in  8  glyph row, MSB = leftmost pixel, valid 1 cycle after font_addr
- busy  out  1  clear in progress
- hcount_out, vcount_out  out  11  delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing
- rgb_out  out  12  composited pixel

Function
REQ-009 Glyph cell SHALL be 8 px wide by 16 lines; box spans X_POS..X_POS+8*COLS-1 and Y_POS..Y_POS+16*ROWS-1 inclusive.
REQ-010 Character buffer SHALL hold COLS*ROWS 7-bit codes, read synchronously.
REQ-011 A write with char_we=1, busy=0 and char_addr<COLS*ROWS SHALL update the cell on that clk edge.
REQ-012 Writes with char_addr>=COLS*ROWS, or while busy=1, SHALL be ignored.
REQ-013 clear=1 with busy=0 SHALL set busy=1 on the next cycle and write code 7'h20 (space) to cells 0..COLS*ROWS-1, one per cycle in ascending order.
REQ-014 busy SHALL deassert the cycle after the last cell is written, so a clear lasts COLS*ROWS cycles.
REQ-015 clear asserted while busy=1 SHALL be ignored and SHALL NOT restart the sweep.
REQ-016 Pipeline SHALL be 3 stages:
- S1: compute in-box flag, cell col=(h-X_POS)>>3, row=(v-Y_POS)>>4, buffer read.
- S2: drive font_addr={code, (v-Y_POS)[3:0]} as a register.
- S3: select font_data bit 7-(h-X_POS)[2:0].
REQ-017 All *_out timing and counter signals SHALL equal the corresponding inputs delayed exactly 3 clk cycles.
REQ-018 rgb_out SHALL be:
- rgb_in delayed 3 cycles when hblnk or vblnk is set, or the pixel is outside the box.
- FG_COLOR when inside the box and the glyph bit is 1.
- BG_COLOR when inside the box and the glyph bit is 0.
REQ-019 Offset arithmetic SHALL be 11-bit unsigned with explicit in-box comparison first; pixels with h<X_POS or v<Y_POS are outside, never wrap to a cell.
REQ-020 Display reads SHALL continue during a clear; pixels then show old or space codes without stalling the pipeline.
REQ-021 A simultaneous char_we and clear with busy=0 SHALL start the clear and drop the write.

Reset
REQ-022 On rst=1 all *_out, rgb_out and font_addr SHALL be 0 on the next edge.
REQ-023 Release of rst SHALL start an automatic clear (busy=1 the cycle after rst deasserts, sweep per REQ-013).
REQ-024 rst asserted mid-clear SHALL abort the sweep; release SHALL restart it from cell 0.
REQ-025 Pipeline registers SHALL hold 0 while rst=1; no valid pixel emerges until 3 cycles after release.

Verification
REQ-026 Release rst, defaults -> busy high exactly 64 cycles; all cells read 7'h20.
REQ-027 Write code 7'h41 at addr 0, h=64, v=64+5, font_data=8'b1000_0000 -> font_addr=11'h415 seen; rgb_out=12'h000 three cycles after h=64, 12'hfff for h=65.
REQ-028 h=63 or h=192, v inside -> rgb_out equals rgb_in from 3 cycles earlier; hblnk_in=1 inside box -> passthrough.
REQ-029 Write addr 64 (COLS*ROWS) and a write during busy -> buffer contents unchanged.
REQ-030 clear pulsed at cycle 10 of a running clear, then rst mid-sweep -> no restart at cycle 10; after rst release busy rises again and lasts 64 cycles.
REQ-031 Random hcount/vcount/sync stream -> every *_out matches its input delayed by 3 cycles.
